gf180mcu_fd_sc_mcu9t5v0__nor_filt: RTL and testbench

Parametrised WIDTH-input NOR with a registered, debounced output, a sticky event flag and a saturating event counter. Sits alongside the 9-track combinational NOR cells as the clocked, glitch-filtered variant for wake-up, fault-OR and zero-detect paths. A raw combinational NOR output is also provided. Supply pins are carried as in the rest of the library.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__nor_filt.sv | 182 ++++++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__nor_filt.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nor_filt.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__nor_filt
//
// Clocked, glitch-filtered WIDTH-input NOR. The inputs are sampled every
// cycle. The NOR of the sample must hold a new value for DEBOUNCE
// consecutive qualifying edges before the registered output ZN follows it.
// Every ZN fall (1->0) is an event. An event sets the sticky flag EVT and
// increments the saturating counter CNT. ZN_RAW is the unfiltered
// combinational NOR of A.
//
// Parameters:
//   WIDTH    number of NOR inputs (2..32)
//   DEBOUNCE consecutive qualifying cycles before ZN changes (1..15)
//   CNT_W    event counter width (1..16)
//
// Ports:
//   CLK     clock, all state updates on the rising edge
//   RN      asynchronous active-low reset
//   A       NOR data inputs
//   EN      filter enable; low freezes ZN and aborts any qualification
//   CLR     synchronous clear of EVT and CNT; an event at the same edge wins
//   ZN      registered, debounced NOR of A
//   ZN_RAW  combinational ~|A
//   EVT     sticky flag, set on each ZN fall
//   CNT     saturating count of ZN falls
//   VDD/VSS supply pins, carried for library consistency
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__nor_filt #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned DEBOUNCE = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic [WIDTH-1:0] A,
  input  logic             EN,
  input  logic             CLR,
  output logic             ZN,
  output logic             ZN_RAW,
  output logic             EVT,
  output logic [CNT_W-1:0] CNT,
  inout  wire              VDD,
  inout  wire              VSS
);

  typedef enum logic [1:0] {
    HI  = 2'd0,  // ZN = 1, stable
    QLO = 2'd1,  // qualifying a fall
    LO  = 2'd2,  // ZN = 0, stable
    QHI = 2'd3   // qualifying a rise
  } state_t;

  localparam logic [4:0]       DB      = 5'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] s;
  logic [3:0]       q;
  logic [4:0]       q_inc;
  logic             nor_s;
  logic             fall;
  logic             rise;

  // The supply pins carry no logic function in the behavioural model.
  logic unused_supply;
  assign unused_supply = VDD ^ VSS;

  assign ZN_RAW = ~|A;
  assign nor_s  = ~|s;
  assign q_inc  = {1'b0, q} + 5'd1;

  // fall/rise flag the edge at which qualification completes. The FSM uses
  // them, and so does the event logic, so the two cannot disagree.
  always_comb begin
    fall = 1'b0;
    rise = 1'b0;
    if (EN) begin
      case (state)
        HI:      fall = !nor_s && (DB == 5'd1);
        QLO:     fall = !nor_s && (q_inc == DB);
        LO:      rise =  nor_s && (DB == 5'd1);
        QHI:     rise =  nor_s && (q_inc == DB);
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      s     <= '0;
      state <= HI;
      q     <= '0;
      ZN    <= 1'b1;
      EVT   <= 1'b0;
      CNT   <= '0;
    end else begin
      // The sample register runs regardless of EN.
      s <= A;

      if (!EN) begin
        // Hold ZN. Drop any partial qualification back to the stable
        // state that matches ZN.
        q <= '0;
        case (state)
          QLO:     state <= HI;
          QHI:     state <= LO;
          default: ;
        endcase
      end else begin
        case (state)
          HI: begin
            if (!nor_s) begin
              if (fall) begin
                state <= LO;
                ZN    <= 1'b0;
                q     <= '0;
              end else begin
                state <= QLO;
                q     <= 4'd1;
              end
            end
          end
          QLO: begin
            if (nor_s) begin
              state <= HI;
              q     <= '0;
            end else if (fall) begin
              state <= LO;
              ZN    <= 1'b0;
              q     <= '0;
            end else begin
              q <= q_inc[3:0];
            end
          end
          LO: begin
            if (nor_s) begin
              if (rise) begin
                state <= HI;
                ZN    <= 1'b1;
                q     <= '0;
              end else begin
                state <= QHI;
                q     <= 4'd1;
              end
            end
          end
          QHI: begin
            if (!nor_s) begin
              state <= LO;
              q     <= '0;
            end else if (rise) begin
              state <= HI;
              ZN    <= 1'b1;
              q     <= '0;
            end else begin
              q <= q_inc[3:0];
            end
          end
          default: begin
            state <= HI;
            ZN    <= 1'b1;
            q     <= '0;
          end
        endcase
      end

      // An event takes priority over a coincident clear. The clear still
      // wipes the old count, so the count restarts at one.
      if (fall) begin
        EVT <= 1'b1;
        if (CLR)
          CNT <= CNT_W'(1);
        else if (CNT != CNT_MAX)
          CNT <= CNT + 1'b1;
      end else if (CLR) begin
        EVT <= 1'b0;
        CNT <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__nor_filt.sv
module tb_gf180mcu_fd_sc_mcu9t5v0__nor_filt;

  logic       CLK;
  logic       RN;
  logic [2:0] A;
  logic       EN;
  logic       CLR;
  logic       ZN;
  logic       ZN_RAW;
  logic       EVT;
  logic [1:0] CNT;
  wire        vdd;
  wire        vss;

  assign vdd = 1'b1;
  assign vss = 1'b0;

  gf180mcu_fd_sc_mcu9t5v0__nor_filt #(
    .WIDTH    (3),
    .DEBOUNCE (2),
    .CNT_W    (2)
  ) dut (
    .CLK    (CLK),
    .RN     (RN),
    .A      (A),
    .EN     (EN),
    .CLR    (CLR),
    .ZN     (ZN),
    .ZN_RAW (ZN_RAW),
    .EVT    (EVT),
    .CNT    (CNT),
    .VDD    (vdd),
    .VSS    (vss)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string      nm;
    logic       zn;
    logic       raw;
    logic       evt;
    logic [1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Monitor: outputs are sampled at the falling edge. Each falling edge
  // consumes at most one queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({ZN, ZN_RAW, EVT, CNT} !== {e.zn, e.raw, e.evt, e.cnt}) begin
          n_fail++;
          $display("FAIL %s: got zn=%b raw=%b evt=%b cnt=%0d, want zn=%b raw=%b evt=%b cnt=%0d",
                   e.nm, ZN, ZN_RAW, EVT, CNT, e.zn, e.raw, e.evt, e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input string nm, input logic zn, input logic raw,
                      input logic evt, input logic [1:0] cnt);
    exp_t e;
    e.nm  = nm;
    e.zn  = zn;
    e.raw = raw;
    e.evt = evt;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs, just after a falling edge. Queue the outputs
  // expected after the next rising edge. Return just after the following
  // falling edge.
  task automatic cyc(input logic [2:0] a, input logic en, input logic clr,
                     input logic zn, input logic evt, input logic [1:0] cnt,
                     input string nm);
    A   = a;
    EN  = en;
    CLR = clr;
    @(posedge CLK);
    push(nm, zn, ~|a, evt, cnt);
    @(negedge CLK);
    #1;
  endtask

  // One fully qualified fall and recovery, starting from HI with S = 0.
  task automatic ev_seq(input logic [2:0] a, input logic evt_b,
                        input logic [1:0] cnt_b, input logic clr_on_event,
                        input logic [1:0] cnt_a, input string nm);
    cyc(a,    1'b1, 1'b0,         1'b1, evt_b, cnt_b, {nm, "_cap"});
    cyc(a,    1'b1, 1'b0,         1'b1, evt_b, cnt_b, {nm, "_qlo"});
    cyc(a,    1'b1, clr_on_event, 1'b0, 1'b1,  cnt_a, {nm, "_fall"});
    cyc(3'b0, 1'b1, 1'b0,         1'b0, 1'b1,  cnt_a, {nm, "_lo"});
    cyc(3'b0, 1'b1, 1'b0,         1'b0, 1'b1,  cnt_a, {nm, "_qhi"});
    cyc(3'b0, 1'b1, 1'b0,         1'b1, 1'b1,  cnt_a, {nm, "_rise"});
  endtask

  initial begin
    RN  = 1'b0;
    A   = 3'b101;
    EN  = 1'b1;
    CLR = 1'b0;
    push("reset", 1'b1, 1'b0, 1'b0, 2'd0);
    @(negedge CLK);
    #1;
    RN = 1'b1;

    // Reset release: ZN stays high with A = 0.
    cyc(3'b000, 1, 0, 1, 0, 2'd0, "rel0");
    cyc(3'b000, 1, 0, 1, 0, 2'd0, "rel1");

    // Debounced fall, then debounced rise (no event on the rise).
    cyc(3'b010, 1, 0, 1, 0, 2'd0, "db_cap");
    cyc(3'b010, 1, 0, 1, 0, 2'd0, "db_qlo");
    cyc(3'b010, 1, 0, 0, 1, 2'd1, "db_fall");
    cyc(3'b000, 1, 0, 0, 1, 2'd1, "db_lo");
    cyc(3'b000, 1, 0, 0, 1, 2'd1, "db_qhi");
    cyc(3'b000, 1, 0, 1, 1, 2'd1, "db_rise");

    cyc(3'b000, 1, 1, 1, 0, 2'd0, "clr0");

    // One-cycle glitch: ZN_RAW pulses, ZN/EVT/CNT do not move.
    cyc(3'b001, 1, 0, 1, 0, 2'd0, "gl_pulse");
    cyc(3'b000, 1, 0, 1, 0, 2'd0, "gl_qlo");
    cyc(3'b000, 1, 0, 1, 0, 2'd0, "gl_abort");
    cyc(3'b000, 1, 0, 1, 0, 2'd0, "gl_hi");

    // Filter disabled while A is held, then enabled.
    for (int i = 0; i < 5; i++)
      cyc(3'b100, 0, 0, 1, 0, 2'd0, "en_off");
    cyc(3'b100, 1, 0, 1, 0, 2'd0, "en_on_qlo");
    cyc(3'b100, 1, 0, 0, 1, 2'd1, "en_on_fall");

    // EN dropped on the would-be completing edge of a rise.
    cyc(3'b000, 1, 0, 0, 1, 2'd1, "enr_lo");
    cyc(3'b000, 1, 0, 0, 1, 2'd1, "enr_qhi");
    cyc(3'b000, 0, 0, 0, 1, 2'd1, "enr_blocked");
    cyc(3'b000, 1, 0, 0, 1, 2'd1, "enr_restart");
    cyc(3'b000, 1, 0, 1, 1, 2'd1, "enr_rise");

    // Saturation and clear.
    cyc(3'b000, 1, 1, 1, 0, 2'd0, "clr1");
    ev_seq(3'b001, 0, 2'd0, 0, 2'd1, "sat1");
    ev_seq(3'b010, 1, 2'd1, 0, 2'd2, "sat2");
    ev_seq(3'b110, 1, 2'd2, 0, 2'd3, "sat3");
    ev_seq(3'b111, 1, 2'd3, 0, 2'd3, "sat4");
    ev_seq(3'b100, 1, 2'd3, 1, 2'd1, "clr_ev");
    cyc(3'b000, 1, 1, 1, 0, 2'd0, "clr_only");

    // Reset during QLO aborts the fall with no event.
    cyc(3'b011, 1, 0, 1, 0, 2'd0, "rq_cap");
    cyc(3'b011, 1, 0, 1, 0, 2'd0, "rq_qlo");
    RN = 1'b0;
    push("rst_qlo", 1'b1, 1'b0, 1'b0, 2'd0);
    @(negedge CLK);
    #1;
    RN = 1'b1;
    cyc(3'b011, 1, 0, 1, 0, 2'd0, "rq_recap");
    cyc(3'b011, 1, 0, 1, 0, 2'd0, "rq_requal");
    cyc(3'b011, 1, 0, 0, 1, 2'd1, "rq_fall");
    cyc(3'b000, 1, 0, 0, 1, 2'd1, "rq_lo");
    cyc(3'b000, 1, 0, 0, 1, 2'd1, "rq_qhi");
    cyc(3'b000, 1, 0, 1, 1, 2'd1, "rq_rise");
    cyc(3'b101, 1, 0, 1, 1, 2'd1, "rl_cap");
    cyc(3'b101, 1, 0, 1, 1, 2'd1, "rl_qlo");
    cyc(3'b101, 1, 0, 0, 1, 2'd2, "rl_fall");

    // Reset in LO with CNT = 2. It must act before the next rising edge.
    @(posedge CLK);
    #1;
    RN = 1'b0;
    push("rst_async", 1'b1, 1'b0, 1'b0, 2'd0);
    @(negedge CLK);
    #1;
    RN = 1'b1;
    cyc(3'b000, 1, 0, 1, 0, 2'd0, "post_rst");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++)
      @(negedge CLK);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
